// File: rtl/otter_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : otter_mem_pkg
// Brief  : Shared types for the OTTER memory arbiter and data-memory wrapper.
// Rev    : 1.0  initial release
// ============================================================================
package otter_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } size_e;

   typedef enum logic {
      PORT1 = 1'b0,
      PORT2 = 1'b1
   } owner_e;

endpackage
`default_nettype wire

// File: rtl/otter_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : otter_mem_arbiter_if
// Brief  : Fetch port, data port and shared memory bus of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface otter_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              MA_REQ1;
   logic [ADDR_W-1:0] MA_ADDR1;
   logic [DATA_W-1:0] MA_RDATA1;
   logic              MA_DONE1;

   logic              MA_REQ2;
   logic              MA_WE2;
   logic [ADDR_W-1:0] MA_ADDR2;
   logic [DATA_W-1:0] MA_WDATA2;
   logic [1:0]        MA_SIZE2;
   logic [DATA_W-1:0] MA_RDATA2;
   logic              MA_DONE2;

   logic              MEM_REQ;
   logic              MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [DATA_W-1:0] MEM_WDATA;
   logic [1:0]        MEM_SIZE;
   logic [DATA_W-1:0] MEM_RDATA;
   logic              MEM_ACK;
   logic              MA_ERR;

   // Arbiter side
   modport slave (
      input  MA_REQ1, MA_ADDR1,
      input  MA_REQ2, MA_WE2, MA_ADDR2, MA_WDATA2, MA_SIZE2,
      input  MEM_RDATA, MEM_ACK,
      output MA_RDATA1, MA_DONE1, MA_RDATA2, MA_DONE2,
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MA_ERR
   );

   // Requesters plus memory
   modport master (
      output MA_REQ1, MA_ADDR1,
      output MA_REQ2, MA_WE2, MA_ADDR2, MA_WDATA2, MA_SIZE2,
      output MEM_RDATA, MEM_ACK,
      input  MA_RDATA1, MA_DONE1, MA_RDATA2, MA_DONE2,
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MA_ERR
   );
endinterface
`default_nettype wire

// File: rtl/otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : otter_mem_arbiter
// Brief  : Round-robin two-port arbiter (fetch / load-store) onto one memory
//          bus, with an ACK timeout that aborts the access and flags MA_ERR.
// Rev    : 1.0  initial release
// ============================================================================
module otter_mem_arbiter
   import otter_mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                 MA_CLK,
   input  logic                 MA_RESET_N,
   otter_mem_arbiter_if.slave   bus
);

   localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

   state_e            state_q,     state_d;
   owner_e            owner_q,     owner_d;
   logic              prefer2_q,   prefer2_d;
   logic [7:0]        timer_q,     timer_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        mem_size_q,  mem_size_d;
   logic [DATA_W-1:0] rdata1_q,    rdata1_d;
   logic [DATA_W-1:0] rdata2_q,    rdata2_d;
   logic              done1_q,     done1_d;
   logic              done2_q,     done2_d;
   logic              err_q,       err_d;
   logic              grant2;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      prefer2_d   = prefer2_q;
      timer_d     = timer_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_size_d  = mem_size_q;
      rdata1_d    = rdata1_q;
      rdata2_d    = rdata2_q;
      done1_d     = 1'b0;
      done2_d     = 1'b0;
      err_d       = 1'b0;
      grant2      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.MA_REQ1 || bus.MA_REQ2) begin
               // Port 2 wins alone, or on a tie when port 1 was served last
               grant2    = bus.MA_REQ2 && (!bus.MA_REQ1 || prefer2_q);
               owner_d   = grant2 ? PORT2 : PORT1;
               prefer2_d = !grant2;
               mem_req_d = 1'b1;
               timer_d   = 8'd0;
               state_d   = BUSY;
               if (grant2) begin
                  mem_we_d    = bus.MA_WE2;
                  mem_addr_d  = bus.MA_ADDR2;
                  mem_wdata_d = bus.MA_WDATA2;
                  mem_size_d  = bus.MA_SIZE2;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.MA_ADDR1;
                  mem_wdata_d = '0;
                  mem_size_d  = WORD;
               end
            end
         end

         BUSY: begin
            if (bus.MEM_ACK) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               if (!mem_we_q) begin
                  if (owner_q == PORT2) rdata2_d = bus.MEM_RDATA;
                  else                  rdata1_d = bus.MEM_RDATA;
               end
               done1_d = (owner_q == PORT1);
               done2_d = (owner_q == PORT2);
            end else if (timer_q == c_max_wait) begin
               // Timed out: reads return zero, stores just complete with error
               mem_req_d = 1'b0;
               state_d   = RESP;
               err_d     = 1'b1;
               if (!mem_we_q) begin
                  if (owner_q == PORT2) rdata2_d = '0;
                  else                  rdata1_d = '0;
               end
               done1_d = (owner_q == PORT1);
               done2_d = (owner_q == PORT2);
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge MA_CLK) begin
      if (!MA_RESET_N) begin
         state_q     <= IDLE;
         owner_q     <= PORT1;
         prefer2_q   <= 1'b0;
         timer_q     <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_size_q  <= 2'b00;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
         done1_q     <= 1'b0;
         done2_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         prefer2_q   <= prefer2_d;
         timer_q     <= timer_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_size_q  <= mem_size_d;
         rdata1_q    <= rdata1_d;
         rdata2_q    <= rdata2_d;
         done1_q     <= done1_d;
         done2_q     <= done2_d;
         err_q       <= err_d;
      end
   end

   assign bus.MEM_REQ   = mem_req_q;
   assign bus.MEM_WE    = mem_we_q;
   assign bus.MEM_ADDR  = mem_addr_q;
   assign bus.MEM_WDATA = mem_wdata_q;
   assign bus.MEM_SIZE  = mem_size_q;
   assign bus.MA_RDATA1 = rdata1_q;
   assign bus.MA_RDATA2 = rdata2_q;
   assign bus.MA_DONE1  = done1_q;
   assign bus.MA_DONE2  = done2_q;
   assign bus.MA_ERR    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_otter_mem_arbiter
// Brief  : Self-checking bench: directed scenarios then randomized traffic
//          against a transaction-level model of grant order and completion.
// Rev    : 1.0  initial release
// ============================================================================
module tb_otter_mem_arbiter;
   import otter_mem_pkg::*;

   localparam int MAX_WAIT = 15;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   // Requester intent and expected architectural state
   logic        p1_req, p2_req, p2_we;
   logic [31:0] p1_addr, p2_addr, p2_wdata;
   logic [1:0]  p2_size;
   logic [31:0] exp_rdata1, exp_rdata2;
   int          last_port;

   otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   otter_mem_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .MA_CLK     (clk),
      .MA_RESET_N (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      bus.MA_REQ1   = p1_req;
      bus.MA_ADDR1  = p1_addr;
      bus.MA_REQ2   = p2_req;
      bus.MA_WE2    = p2_we;
      bus.MA_ADDR2  = p2_addr;
      bus.MA_WDATA2 = p2_wdata;
      bus.MA_SIZE2  = p2_size;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_memreq"}, bus.MEM_REQ, 0);
      check({tag, "_done1"},  bus.MA_DONE1, 0);
      check({tag, "_done2"},  bus.MA_DONE2, 0);
      check({tag, "_err"},    bus.MA_ERR, 0);
      check({tag, "_rdata1"}, bus.MA_RDATA1, exp_rdata1);
      check({tag, "_rdata2"}, bus.MA_RDATA2, exp_rdata2);
   endtask

   // One complete access from an IDLE arbiter. k = BUSY cycles before ACK;
   // k > MAX_WAIT means the memory never answers.
   task automatic access(input int k, input logic [31:0] rd, input bit wiggle);
      int          w;
      bit          abort;
      logic        e_we;
      logic [31:0] e_addr, e_wdata;
      logic [1:0]  e_size;

      w = (p1_req && p2_req) ? ((last_port == 1) ? 2 : 1) : (p1_req ? 1 : 2);
      if (w == 1) begin
         e_we = 1'b0; e_addr = p1_addr; e_wdata = 32'h0; e_size = 2'b10;
      end else begin
         e_we = p2_we; e_addr = p2_addr; e_wdata = p2_wdata; e_size = p2_size;
      end
      abort = (k > MAX_WAIT);

      drive_inputs();
      bus.MEM_ACK   = 1'($urandom_range(0, 1));
      bus.MEM_RDATA = $urandom;
      tick();
      check("grant_memreq", bus.MEM_REQ, 1);
      check("grant_addr",   bus.MEM_ADDR, e_addr);
      check("grant_we",     bus.MEM_WE, e_we);
      check("grant_size",   bus.MEM_SIZE, e_size);
      if (w == 2) check("grant_wdata", bus.MEM_WDATA, e_wdata);
      check("grant_done1",  bus.MA_DONE1, 0);
      check("grant_done2",  bus.MA_DONE2, 0);

      for (int i = 0; i <= MAX_WAIT; i++) begin
         bus.MEM_ACK   = (i == k);
         bus.MEM_RDATA = (i == k) ? rd : $urandom;
         if (wiggle) begin
            bus.MA_ADDR1  = $urandom;
            bus.MA_ADDR2  = $urandom;
            bus.MA_WDATA2 = $urandom;
            bus.MA_WE2    = 1'($urandom_range(0, 1));
            bus.MA_SIZE2  = 2'($urandom_range(0, 3));
         end
         tick();
         if (i == k || i == MAX_WAIT) break;
         check("busy_memreq", bus.MEM_REQ, 1);
         check("busy_addr",   bus.MEM_ADDR, e_addr);
         check("busy_we",     bus.MEM_WE, e_we);
         check("busy_size",   bus.MEM_SIZE, e_size);
         check("busy_done",   {bus.MA_DONE1, bus.MA_DONE2}, 0);
      end

      if (!e_we) begin
         if (w == 1) exp_rdata1 = abort ? 32'h0 : rd;
         else        exp_rdata2 = abort ? 32'h0 : rd;
      end
      check("resp_done1",  bus.MA_DONE1, (w == 1));
      check("resp_done2",  bus.MA_DONE2, (w == 2));
      check("resp_err",    bus.MA_ERR, abort);
      check("resp_memreq", bus.MEM_REQ, 0);
      check("resp_rdata1", bus.MA_RDATA1, exp_rdata1);
      check("resp_rdata2", bus.MA_RDATA2, exp_rdata2);

      last_port = w;
      if (w == 1) p1_req = 1'b0;
      else        p2_req = 1'b0;
      drive_inputs();
      // A stray ACK in RESP must have no effect
      bus.MEM_ACK   = 1'($urandom_range(0, 1));
      bus.MEM_RDATA = $urandom;
      tick();
      check_quiet("post");
      bus.MEM_ACK = 1'b0;
   endtask

   task automatic new_p1();
      p1_req  = 1'b1;
      p1_addr = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic new_p2();
      p2_req   = 1'b1;
      p2_we    = 1'($urandom_range(0, 1));
      p2_addr  = $urandom;
      p2_wdata = $urandom;
      p2_size  = 2'($urandom_range(0, 2));
   endtask

   initial begin
      p1_req = 1'b0; p1_addr = '0;
      p2_req = 1'b0; p2_we = 1'b0; p2_addr = '0; p2_wdata = '0; p2_size = 2'b00;
      exp_rdata1 = '0; exp_rdata2 = '0;
      last_port = 2;
      drive_inputs();
      bus.MEM_ACK = 1'b0; bus.MEM_RDATA = '0;

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      check_quiet("rst");
      check("rst_we",    bus.MEM_WE, 0);
      check("rst_addr",  bus.MEM_ADDR, 0);
      check("rst_wdata", bus.MEM_WDATA, 0);
      check("rst_size",  bus.MEM_SIZE, 0);
      rst_n = 1'b1;

      // Tie from reset: port 1, port 2, port 1
      p1_req = 1'b1; p1_addr = 32'h0000_0400;
      p2_req = 1'b1; p2_we = 1'b0; p2_addr = 32'h0000_8000; p2_size = 2'b10;
      access(0, 32'h1111_1111, 1'b0);
      check("rr_first_port1", exp_rdata1, 32'h1111_1111);
      p1_req = 1'b1; p1_addr = 32'h0000_0404;
      access(0, 32'h2222_2222, 1'b0);
      check("rr_second_port2", exp_rdata2, 32'h2222_2222);
      p2_req = 1'b1;
      access(0, 32'h3333_3333, 1'b0);
      check("rr_third_port1", exp_rdata1, 32'h3333_3333);
      p2_req = 1'b0;
      drive_inputs();
      tick();

      // Plain fetch
      p1_req = 1'b1; p1_addr = 32'h0000_0100;
      access(0, 32'hDEAD_BEEF, 1'b0);
      check("fetch_rdata1", bus.MA_RDATA1, 32'hDEAD_BEEF);

      // Byte store leaves RDATA2 alone
      p2_req = 1'b1; p2_we = 1'b1; p2_addr = 32'h0000_2004;
      p2_wdata = 32'h0000_0055; p2_size = 2'b00;
      access(1, 32'hCAFE_F00D, 1'b0);
      check("store_rdata2", bus.MA_RDATA2, 32'h2222_2222);

      // Timeout on a fetch
      p1_req = 1'b1; p1_addr = 32'h0000_0200;
      access(MAX_WAIT + 1, 32'h0, 1'b0);
      check("timeout_rdata1", bus.MA_RDATA1, 32'h0);

      // ACK on the final allowed BUSY cycle still completes normally
      p1_req = 1'b1; p1_addr = 32'h0000_0300;
      access(MAX_WAIT, 32'h7777_0001, 1'b0);

      // Inputs changing mid-access are ignored
      p2_req = 1'b1; p2_we = 1'b0; p2_addr = 32'h0000_3000; p2_size = 2'b01;
      access(3, 32'hABCD_1234, 1'b1);

      // Reset in the middle of an access
      p2_req = 1'b1; p2_we = 1'b0; p2_addr = 32'h0000_5000; p2_size = 2'b10;
      drive_inputs();
      tick();
      check("midrst_busy", bus.MEM_REQ, 1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_rdata1 = '0; exp_rdata2 = '0; last_port = 2;
      check_quiet("midrst");
      check("midrst_addr", bus.MEM_ADDR, 0);
      p2_req = 1'b0;
      drive_inputs();
      bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h9999_9999;
      tick();
      check_quiet("lateack");
      bus.MEM_ACK = 1'b0;

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         if (!p1_req && ($urandom_range(0, 1) == 1)) new_p1();
         if (!p2_req && ($urandom_range(0, 1) == 1)) new_p2();
         if (!p1_req && !p2_req) begin
            drive_inputs();
            bus.MEM_ACK   = 1'($urandom_range(0, 1));
            bus.MEM_RDATA = $urandom;
            tick();
            check_quiet("idle");
            bus.MEM_ACK = 1'b0;
         end else begin
            access($urandom_range(0, MAX_WAIT + 3), $urandom, 1'($urandom_range(0, 1)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/otter_mem_arbiter.md
OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width on all ports SHALL be ADDR_W.
REQ-002 Parameter DATA_W, default 32, data width on all ports SHALL be DATA_W.
REQ-003 Parameter MAX_WAIT, default 15, cycles in BUSY without MEM_ACK before abort; SHALL be 1..255.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low:
  MA_CLK  in  1  clock, all state on rising edge
  MA_RESET_N  in  1  synchronous active-low reset
REQ-005 Port 1 (instruction fetch, read-only):
  MA_REQ1  in  1  fetch request, held until MA_DONE1
  MA_ADDR1  in  ADDR_W  fetch address
  MA_RDATA1  out  DATA_W  fetch data, registered
  MA_DONE1  out  1  one-cycle completion pulse
REQ-006 Port 2 (data, load/store):
  MA_REQ2  in  1  data request, held until MA_DONE2
  MA_WE2  in  1  1=store, 0=load
  MA_ADDR2  in  ADDR_W  data address
  MA_WDATA2  in  DATA_W  store data
  MA_SIZE2  in  2  00 byte, 01 half, 10 word
  MA_RDATA2  out  DATA_W  load data, registered
  MA_DONE2  out  1  one-cycle completion pulse
REQ-007 Shared memory side and status:
  MEM_REQ  out  1  access active, held until MEM_ACK or abort
  MEM_WE  out  1  write enable
  MEM_ADDR  out  ADDR_W  address
  MEM_WDATA  out  DATA_W  write data
  MEM_SIZE  out  2  access size (port 1 always 10)
  MEM_RDATA  in  DATA_W  read data, valid with MEM_ACK
  MEM_ACK  in  1  access complete
  MA_ERR  out  1  pulses with DONE when access timed out

Function
REQ-008 FSM states SHALL be IDLE, BUSY, RESP; every MEM_*/MA_* output SHALL be driven from registers.
REQ-009 IDLE: if neither REQ high, remain IDLE; otherwise grant, latch owner, MEM_WE/ADDR/WDATA/SIZE, set MEM_REQ, clear timer, go BUSY.
REQ-010 Arbitration SHALL be round-robin: single requester wins; both high -> port not granted last wins; after reset port 1 wins first tie.
REQ-011 BUSY: MEM_REQ and latched fields SHALL stay constant; requester input changes SHALL be ignored.
REQ-012 BUSY with MEM_ACK=1: capture MEM_RDATA into owner's RDATA (loads and fetches only; stores leave RDATA unchanged), clear MEM_REQ, go RESP.
REQ-013 BUSY without MEM_ACK: timer increments; when timer reaches MAX_WAIT, clear MEM_REQ, set owner's RDATA=0 (reads), set MA_ERR, go RESP.
REQ-014 RESP: owner's DONE=1 for exactly this cycle, MA_ERR=1 only if aborted, then IDLE unconditionally; REQ inputs not sampled in RESP.
REQ-015 Latency: REQ high in IDLE cycle N -> MEM_REQ high from N+1; MEM_ACK in cycle M>=N+1 -> DONE in M+1; minimum request-to-DONE 2 cycles, back-to-back grant every 3 cycles.
REQ-016 MEM_ACK sampled in IDLE or RESP SHALL be ignored.
REQ-017 RDATA1/RDATA2 SHALL hold value until the next completed read on that port.
REQ-018 At most one DONE SHALL be high in any cycle; DONE never asserts for a port not owning the access.

Reset
REQ-019 MA_RESET_N=0 at a clock edge SHALL force IDLE, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_SIZE=0, DONE1=DONE2=0, MA_ERR=0, RDATA1=RDATA2=0, timer=0, round-robin pointer to favour port 1.
REQ-020 Reset during BUSY SHALL abandon the access with no DONE pulse; requesters re-issue.

Structure
REQ-021 Package otter_mem_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and size enum (BYTE, HALF, WORD); shared with the data-memory wrapper.
REQ-022 No sub-module; timer, pointer, FSM in one module.

Verification
REQ-023 REQ1=1 ADDR1=0x100, memory ACKs 1 cycle after MEM_REQ with 0xDEADBEEF -> MEM_ADDR=0x100 MEM_SIZE=10, DONE1 one cycle, RDATA1=0xDEADBEEF, MA_ERR=0.
REQ-024 REQ1 and REQ2 both high from reset, ACK each immediately -> port 1 served first, port 2 second, then with both still requesting port 1 again (alternation).
REQ-025 REQ2=1 WE2=1 ADDR2=0x2004 WDATA2=0x55 SIZE2=00 -> MEM_WE=1 MEM_SIZE=00 MEM_WDATA=0x55, DONE2 pulse, RDATA2 unchanged.
REQ-026 MAX_WAIT=15, no MEM_ACK -> MEM_REQ high exactly 16 cycles, then DONE1 and MA_ERR together one cycle, RDATA1=0.
REQ-027 MA_RESET_N=0 for one cycle during BUSY -> next cycle IDLE, MEM_REQ=0, no DONE; late MEM_ACK ignored.
REQ-028 Change ADDR2 mid-BUSY and pulse MEM_ACK while IDLE -> MEM_ADDR unchanged, no spurious DONE.
